// File: rtl/arch_state_dumper.sv
// arch_state_dumper: end-of-run architectural state reader for the single-cycle machine
// Watches inst and a cycle budget. On halt it walks the register file and then a
// data-memory window, emitting each word on a valid/ready stream.
// Optional feature macro: ARCH_STATE_PC_TRACE_EN (per-clock PC trace during RUN plus trace_drops).
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   inst, pc          instruction fetched by machine and its byte PC
//   rf_raddr/rf_rdata spare register-file read port (combinational data)
//   mem_raddr/mem_rdata spare data-memory read port, word index (combinational data)
//   out_valid/out_ready/out_data/out_kind  dump stream (kind 0=PC, 1=register, 2=memory)
//   halted, dump_done sticky status flags
//   trace_drops       saturating count of unaccepted PC trace words (macro only)
module arch_state_dumper #(
    parameter int          NUM_REGS   = 32,
    parameter logic [31:0] MEM_BASE   = 32'h4000,
    parameter int          MEM_WORDS  = 4,
    parameter int          MAX_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [1:0]  out_kind,
    output logic        halted,
    output logic        dump_done
`ifdef ARCH_STATE_PC_TRACE_EN
    ,
    output logic [15:0] trace_drops
`endif
);
    localparam int TOTAL = NUM_REGS + MEM_WORDS;
    localparam int IW    = $clog2(TOTAL);
    localparam int CW    = $clog2(MAX_CYCLES + 1);
    localparam logic [IW-1:0] NREG_I = IW'(NUM_REGS);
    localparam logic [IW-1:0] LAST_I = IW'(TOTAL - 1);
    localparam logic [CW-1:0] CMAX   = CW'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {RUN, FETCH, PRESENT, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [IW-1:0] idx, idx_n;
    logic [31:0]   data_n;
    logic [1:0]    kind_n;
    logic          valid_n, halted_n, done_n;
    logic [4:0]    rf_q;
    logic [31:0]   mem_q;
    logic          is_reg, halt_now, accept;

    assign is_reg   = idx < NREG_I;
    // A zero instruction only counts once the first RUN cycle is behind us;
    // an x/z instruction never matches the case-equality test.
    assign halt_now = (count == CMAX) || (count != '0 && inst === 32'h0);
    assign accept   = out_valid && out_ready;
    // Addresses are driven from idx only while fetching, otherwise they hold.
    assign rf_raddr  = (state == FETCH && is_reg) ? 5'(idx) : rf_q;
    assign mem_raddr = (state == FETCH && !is_reg) ? MEM_BASE + 32'(idx - NREG_I) : mem_q;

`ifdef ARCH_STATE_PC_TRACE_EN
    logic [15:0] drops_n;
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

    always_comb begin
        state_n  = state;
        count_n  = count;
        idx_n    = idx;
        data_n   = out_data;
        kind_n   = out_kind;
        valid_n  = out_valid;
        halted_n = halted;
        done_n   = dump_done;
`ifdef ARCH_STATE_PC_TRACE_EN
        drops_n  = trace_drops;
`endif
        case (state)
            RUN: begin
                count_n = count + 1'b1;
`ifdef ARCH_STATE_PC_TRACE_EN
                // The trace word is overwritten every clock whether or not it was taken.
                drops_n = (out_valid && !out_ready && trace_drops != 16'hffff) ? trace_drops + 1'b1 : trace_drops;
                valid_n = 1'b1;
                data_n  = pc;
                kind_n  = 2'd0;
`endif
                if (halt_now) begin
                    state_n  = FETCH;
                    halted_n = 1'b1;
                    idx_n    = '0;
                    valid_n  = 1'b0;
                end
            end
            FETCH: begin
                data_n  = is_reg ? rf_rdata : mem_rdata;
                kind_n  = is_reg ? 2'd1 : 2'd2;
                valid_n = 1'b1;
                state_n = PRESENT;
            end
            PRESENT: begin
                if (accept) begin
                    valid_n = 1'b0;
                    state_n = (idx == LAST_I) ? DONE : FETCH;
                    done_n  = idx == LAST_I;
                    idx_n   = (idx == LAST_I) ? idx : idx + 1'b1;
                end
            end
            DONE: valid_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            count     <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_kind  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            dump_done <= 1'b0;
            rf_q      <= '0;
            mem_q     <= MEM_BASE;
`ifdef ARCH_STATE_PC_TRACE_EN
            trace_drops <= '0;
`endif
        end else begin
            state     <= state_n;
            count     <= count_n;
            idx       <= idx_n;
            out_data  <= data_n;
            out_kind  <= kind_n;
            out_valid <= valid_n;
            halted    <= halted_n;
            dump_done <= done_n;
            rf_q      <= rf_raddr;
            mem_q     <= mem_raddr;
`ifdef ARCH_STATE_PC_TRACE_EN
            trace_drops <= drops_n;
`endif
        end
    end
endmodule
